// File: rtl/mpi_link_pkg.sv
// Shared types and defaults for the credit-based MPI link transmit path.
package mpi_link_pkg;

    localparam int FLIT_W             = 64;
    localparam int DEFAULT_CREDITS    = 3;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        LINK_IDLE  = 2'd0,
        LINK_SEND  = 2'd1,
        LINK_STALL = 2'd2
    } link_state_e;

endpackage

// File: rtl/mpi_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data is presented combinationally.
module mpi_sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/mpi_credit_tx.sv
// Credit-based (valid/yummy) transmit stage: buffers local flits and sends one per
// cycle only while the remote receive buffer has a free slot.
//
//   state      | meaning
//   LINK_IDLE  | local buffer empty
//   LINK_SEND  | flits buffered and at least one credit available
//   LINK_STALL | flits buffered but no credits left
module mpi_credit_tx
    import mpi_link_pkg::*;
#(
    parameter int DATA_W     = FLIT_W,
    parameter int CREDITS    = DEFAULT_CREDITS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [DATA_W-1:0]            data_o,
    output logic                         valid_o,
    input  logic                         yummy_i,
    output logic [$clog2(CREDITS+1)-1:0] credits_o,
    output logic [1:0]                   state_o,
    output logic                         err_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level, level_d;
    logic              push, send;

    logic [CW-1:0]     credits_q, credits_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    link_state_e       state_q, state_d;

    assign ready_o = !fifo_full;
    assign push    = valid_i && !fifo_full;
    assign send    = !fifo_empty && (credits_q != '0);

    mpi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (send),
        .data_i  (data_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // A yummy only lands in the counter at the edge, so it cannot unblock a send
    // in the cycle it arrives.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        unique case ({send, yummy_i})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase

        level_d = fifo_level + LW'(push) - LW'(send);

        if (level_d == '0) begin
            state_d = LINK_IDLE;
        end else if (credits_d != '0) begin
            state_d = LINK_SEND;
        end else begin
            state_d = LINK_STALL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= LINK_IDLE;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            case (state_q)
                LINK_IDLE, LINK_SEND, LINK_STALL: state_q <= state_d;
                default:                          state_q <= LINK_IDLE;
            endcase
            credits_q <= credits_d;
            err_q     <= err_d;
            valid_q   <= send;
            if (send) begin
                data_q <= fifo_head;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign credits_o = credits_q;
    assign state_o   = state_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mpi_credit_tx.sv
// Directed and randomized checks of mpi_credit_tx against a queue-based credit model.
module tb_mpi_credit_tx;
    import mpi_link_pkg::*;

    localparam int DW = 64;
    localparam int CR = 3;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          vin;
    logic          rdy;
    logic [DW-1:0] dout;
    logic          vout;
    logic          yum;
    logic [1:0]    cred;
    logic [1:0]    st;
    logic          err;

    always #5 clk = ~clk;

    mpi_credit_tx #(.DATA_W(DW), .CREDITS(CR), .FIFO_DEPTH(FD)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (din),
        .valid_i   (vin),
        .ready_o   (rdy),
        .data_o    (dout),
        .valid_o   (vout),
        .yummy_i   (yum),
        .credits_o (cred),
        .state_o   (st),
        .err_o     (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue for the local buffer and an integer credit count.
    logic [DW-1:0] mq[$];
    int            m_cred;
    bit            m_err;
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_state;
    int            inflight;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit v, input logic [DW-1:0] d, input bit y, input bit r);
        bit send;
        bit push;
        if (r) begin
            mq.delete();
            m_cred   = CR;
            m_err    = 0;
            m_valid  = 0;
            m_data   = '0;
            inflight = 0;
        end else begin
            send = (mq.size() > 0) && (m_cred > 0);
            push = v && (mq.size() < FD);
            m_valid = send;
            if (send) begin
                m_data = mq.pop_front();
                inflight++;
            end
            if (push) mq.push_back(d);
            m_cred = m_cred - int'(send) + int'(y);
            if (m_cred > CR) begin
                m_cred = CR;
                m_err  = 1;
            end
            if (y && inflight > 0) inflight--;
        end
        m_state = (mq.size() == 0) ? 0 : ((m_cred > 0) ? 1 : 2);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},   64'(vout), 64'(m_valid));
        check({tag, ".data"},    dout,      m_data);
        check({tag, ".credits"}, 64'(cred), 64'(m_cred));
        check({tag, ".state"},   64'(st),   64'(m_state));
        check({tag, ".err"},     64'(err),  64'(m_err));
        check({tag, ".ready"},   64'(rdy),  64'(mq.size() < FD));
    endtask

    task automatic cyc(input string tag, input bit v, input logic [DW-1:0] d, input bit y, input bit r);
        rst = r;
        vin = v;
        din = d;
        yum = y;
        model_step(v, d, y, r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        yum = 1'b0;
        mq.delete();

        // Reset
        cyc("rst0", 0, 64'h0, 0, 1);
        cyc("rst1", 0, 64'h0, 0, 1);

        // 1: three back-to-back flits drain all credits
        cyc("t1p1", 1, 64'hA1, 0, 0);
        cyc("t1p2", 1, 64'hA2, 0, 0);
        check("t1_first_out", dout, 64'hA1);
        cyc("t1p3", 1, 64'hA3, 0, 0);
        cyc("t1d1", 0, 64'h0, 0, 0);
        check("t1_last_out", dout, 64'hA3);
        check("t1_cred0", 64'(cred), 64'd0);

        // 2: stalled flit waits for a yummy, leaves the cycle after
        cyc("t2p", 1, 64'hA4, 0, 0);
        check("t2_stall", 64'(st), 64'(LINK_STALL));
        for (int i = 0; i < 4; i++) cyc("t2h", 0, 64'h0, 0, 0);
        cyc("t2y", 0, 64'h0, 1, 0);
        check("t2_not_early", 64'(vout), 64'd0);
        cyc("t2s", 0, 64'h0, 0, 0);
        check("t2_sent", dout, 64'hA4);

        // 3: fill with no credits, fifth push refused, one yummy frees one slot
        for (int i = 0; i < FD; i++) cyc("t3f", 1, 64'hB0 + 64'(i), 0, 0);
        check("t3_full", 64'(rdy), 64'd0);
        cyc("t3x", 1, 64'hBF, 0, 0);
        cyc("t3y", 0, 64'h0, 1, 0);
        cyc("t3s", 0, 64'h0, 0, 0);
        check("t3_one_pop", dout, 64'hB0);
        check("t3_ready", 64'(rdy), 64'd1);

        // 4: send and yummy together at credits 2
        cyc("t4r", 0, 64'h0, 0, 1);
        cyc("t4p1", 1, 64'hC1, 0, 0);
        cyc("t4p2", 1, 64'hC2, 0, 0);
        cyc("t4sy", 0, 64'h0, 1, 0);
        check("t4_cred2", 64'(cred), 64'd2);
        check("t4_valid", 64'(vout), 64'd1);

        // 5: overflowing yummy sets the sticky error
        cyc("t5y1", 0, 64'h0, 1, 0);
        cyc("t5y2", 0, 64'h0, 1, 0);
        check("t5_err", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) cyc("t5h", 0, 64'h0, 0, 0);
        check("t5_sticky", 64'(err), 64'd1);

        // 6: reset with two buffered flits and one credit
        cyc("t6r", 0, 64'h0, 0, 1);
        cyc("t6a", 1, 64'hD1, 0, 0);
        cyc("t6b", 1, 64'hD2, 0, 0);
        cyc("t6c", 1, 64'hD3, 0, 0);
        cyc("t6d", 1, 64'hE1, 0, 0);
        cyc("t6e", 1, 64'hE2, 0, 0);
        cyc("t6y", 0, 64'h0, 1, 0);
        check("t6_cred1", 64'(cred), 64'd1);
        cyc("t6rst", 0, 64'h0, 0, 1);
        check("t6_idle", 64'(st), 64'(LINK_IDLE));
        for (int i = 0; i < 4; i++) begin
            cyc("t6q", 0, 64'h0, 0, 0);
            check("t6_no_emit", 64'(vout), 64'd0);
        end

        // Randomized traffic with mostly legitimate credit returns
        for (int i = 0; i < 400; i++) begin
            bit            v;
            bit            y;
            bit            r;
            logic [DW-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = {$urandom, $urandom};
            y = (inflight > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
            r = (i == 200);
            cyc("rnd", v, d, y, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
